// File: rtl/serial_shift_out_if.sv
// serial_shift_out_if: controller <-> serial transmitter bundle.
// Carries s_lat only when SERIAL_SHIFT_LATCH_EN is defined.
interface serial_shift_out_if #(
    parameter int DATA_BITS = 16
);
    logic [DATA_BITS-1:0] data;
    logic                 start;
    logic                 busy;
    logic                 finish;
    logic                 s_clk;
    logic                 s_clr;
    logic                 s_dat;
`ifdef SERIAL_SHIFT_LATCH_EN
    logic                 s_lat;
    modport master (output data, start, input busy, finish, s_clk, s_clr, s_dat, s_lat);
    modport slave (input data, start, output busy, finish, s_clk, s_clr, s_dat, s_lat);
`else
    modport master (output data, start, input busy, finish, s_clk, s_clr, s_dat);
    modport slave (input data, start, output busy, finish, s_clk, s_clr, s_dat);
`endif
endinterface

// File: rtl/serial_shift_out.sv
// serial_shift_out: parallel-to-serial transmitter for 74HC164-style shift chains.
// SERIAL_SHIFT_LATCH_EN adds a 74HC595-style s_lat phase after the last bit.
module serial_shift_out #(
    parameter int P_CLK_FREQ  = 100,
    parameter int S_CLK_FREQ  = 20,
    parameter int DATA_BITS   = 16,
    parameter int CODE_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_shift_out_if.slave bus
);
    localparam int H_RAW = (P_CLK_FREQ + 2 * S_CLK_FREQ - 1) / (2 * S_CLK_FREQ);
    localparam int H     = H_RAW < 1 ? 1 : H_RAW;
    localparam int CW    = $clog2(2 * H + 1);
    localparam int BW    = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] L_H  = CW'(H);
    localparam logic [CW-1:0] L_HM = CW'(H - 1);
    localparam logic [CW-1:0] L_PM = CW'(2 * H - 1);

`ifdef SERIAL_SHIFT_LATCH_EN
    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, LATCH, DONE} state_t;
    logic r_slat, w_slat;
`else
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;
`endif

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [BW-1:0]        r_bits, w_bits;
    logic [DATA_BITS-1:0] r_sh, w_sh;
    logic                 r_busy, r_finish, r_sclk, r_sclr, r_sdat;
    logic                 w_busy, w_finish, w_sclk, w_sclr, w_sdat, w_head;

    // Outputs are derived from the next state so they leave the flops aligned with it.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + CW'(1);
        w_bits  = r_bits;
        w_sh    = r_sh;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (bus.start) begin
                    w_state = CLEAR;
                    w_sh    = bus.data;
                    w_bits  = BW'(DATA_BITS);
                end
            end
            CLEAR: begin
                if (r_cnt == L_HM) begin
                    w_state = SHIFT;
                    w_cnt   = '0;
                end
            end
            SHIFT: begin
                if (r_cnt == L_PM) begin
                    w_cnt  = '0;
                    w_sh   = CODE_ENDIAN != 0 ? r_sh << 1 : r_sh >> 1;
                    w_bits = r_bits - BW'(1);
`ifdef SERIAL_SHIFT_LATCH_EN
                    if (r_bits == BW'(1)) w_state = LATCH;
`else
                    if (r_bits == BW'(1)) w_state = DONE;
`endif
                end
            end
`ifdef SERIAL_SHIFT_LATCH_EN
            LATCH: begin
                if (r_cnt == L_HM) begin
                    w_state = DONE;
                    w_cnt   = '0;
                end
            end
`endif
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
        w_head   = CODE_ENDIAN != 0 ? w_sh[DATA_BITS-1] : w_sh[0];
        w_busy   = w_state == CLEAR || w_state == SHIFT;
        w_finish = w_state == DONE;
        w_sclk   = w_state == SHIFT && w_cnt >= L_H;
        w_sclr   = w_state == CLEAR;
        w_sdat   = w_state == SHIFT && w_head;
`ifdef SERIAL_SHIFT_LATCH_EN
        w_slat   = w_state == LATCH;
        w_busy   = w_busy || w_slat;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_sh     <= '0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_sclk   <= 1'b0;
            r_sclr   <= 1'b0;
            r_sdat   <= 1'b0;
`ifdef SERIAL_SHIFT_LATCH_EN
            r_slat   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bits   <= w_bits;
            r_sh     <= w_sh;
            r_busy   <= w_busy;
            r_finish <= w_finish;
            r_sclk   <= w_sclk;
            r_sclr   <= w_sclr;
            r_sdat   <= w_sdat;
`ifdef SERIAL_SHIFT_LATCH_EN
            r_slat   <= w_slat;
`endif
        end
    end

    assign bus.busy   = r_busy;
    assign bus.finish = r_finish;
    assign bus.s_clk  = r_sclk;
    assign bus.s_clr  = r_sclr;
    assign bus.s_dat  = r_sdat;
`ifdef SERIAL_SHIFT_LATCH_EN
    assign bus.s_lat  = r_slat;
`endif
endmodule

// File: tb/tb_serial_shift_out.sv
// tb_serial_shift_out: four DUT configurations checked cycle by cycle against a
// timeline model, via a vector table, corner sequences and random transfers.
module tb_serial_shift_out;
    localparam int NV [4] = '{16, 8, 64, 1};
    localparam int EV [4] = '{1, 0, 1, 1};
    localparam int HV [4] = '{3, 3, 2, 3};
`ifdef SERIAL_SHIFT_LATCH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int          inst;
        logic [63:0] d;
        logic [63:0] bits;
        int          fin;
        bit          ign;
        bit          hold;
        int          rst_at;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] t_data [4];
    logic        t_start [4];
    logic [5:0]  obs [4];
    logic [3:0]  lat;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    serial_shift_out_if #(.DATA_BITS(16)) b0 ();
    serial_shift_out_if #(.DATA_BITS(8))  b1 ();
    serial_shift_out_if #(.DATA_BITS(64)) b2 ();
    serial_shift_out_if #(.DATA_BITS(1))  b3 ();

    serial_shift_out #(.DATA_BITS(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
    serial_shift_out #(.DATA_BITS(8), .CODE_ENDIAN(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    serial_shift_out #(.P_CLK_FREQ(50), .DATA_BITS(64)) u2 (.clk(clk), .rst(rst), .bus(b2));
    serial_shift_out #(.DATA_BITS(1)) u3 (.clk(clk), .rst(rst), .bus(b3));

    assign b0.data = t_data[0][15:0];
    assign b1.data = t_data[1][7:0];
    assign b2.data = t_data[2];
    assign b3.data = t_data[3][0:0];
    assign b0.start = t_start[0];
    assign b1.start = t_start[1];
    assign b2.start = t_start[2];
    assign b3.start = t_start[3];
`ifdef SERIAL_SHIFT_LATCH_EN
    assign lat = {b3.s_lat, b2.s_lat, b1.s_lat, b0.s_lat};
`else
    assign lat = 4'b0000;
`endif
    // {busy, finish, s_clk, s_clr, s_dat, s_lat}
    assign obs[0] = {b0.busy, b0.finish, b0.s_clk, b0.s_clr, b0.s_dat, lat[0]};
    assign obs[1] = {b1.busy, b1.finish, b1.s_clk, b1.s_clr, b1.s_dat, lat[1]};
    assign obs[2] = {b2.busy, b2.finish, b2.s_clk, b2.s_clr, b2.s_dat, lat[2]};
    assign obs[3] = {b3.busy, b3.finish, b3.s_clk, b3.s_clr, b3.s_dat, lat[3]};

    // Expected outputs k cycles after the accepting cycle of a single transfer.
    function automatic logic [5:0] model(input int i, input logic [63:0] d, input int k);
        int h = HV[i];
        int n = NV[i];
        int j;
        int b;
        logic [5:0] e = 6'b000000;
        if (k >= 1 && k <= h) e = 6'b100100;
        else if (k > h && k <= h + 2 * h * n) begin
            j = k - h - 1;
            b = j / (2 * h);
            e[5] = 1'b1;
            e[3] = (j % (2 * h)) >= h;
            e[1] = EV[i] != 0 ? d[n - 1 - b] : d[b];
        end else if (LAT != 0 && k > h + 2 * h * n && k <= 2 * h + 2 * h * n) e = 6'b100001;
        else if (k == 1 + h + 2 * h * n + LAT * h) e = 6'b010000;
        return e;
    endfunction

    task automatic check(input string nm, input int id, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d got %h expected %h", nm, id, got, exp);
        end
    endtask

    task automatic xfer(input int id, input int i, input logic [63:0] d, input logic [63:0] bits,
                        input int fin, input bit ign, input bit hold, input int rst_at);
        int n = NV[i];
        int nb = hold ? 2 * n : n;
        int len = hold ? 2 * fin + 6 : fin + 5;
        int nr = 0;
        int nf = 0;
        int ff = -1;
        logic [63:0] cap = '0;
        logic [63:0] mask;
        logic [5:0] e;
        logic pc = 1'b0;
        mask = nb >= 64 ? '1 : (64'd1 << nb) - 64'd1;
        @(negedge clk);
        t_data[i] = d;
        t_start[i] = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            e = (rst_at > 0 && k > rst_at) ? 6'b000000 : model(i, d, k) | (hold ? model(i, d, k - fin - 1) : 6'b000000);
            n_chk++;
            if (obs[i] !== e) begin
                n_fail++;
                $display("FAIL wave vec%0d cyc%0d got %b expected %b", id, k, obs[i], e);
            end
            if (obs[i][3] && !pc) begin
                cap = {cap[62:0], obs[i][1]};
                nr++;
            end
            pc = obs[i][3];
            if (obs[i][4]) begin
                nf++;
                if (ff < 0) ff = k;
            end
            if (!hold || k >= fin + 3) t_start[i] = 1'b0;
            if (ign && k == 10) t_data[i] = '1;
            if (ign && k == 20) t_start[i] = 1'b1;
            if (rst_at > 0 && k == rst_at) rst = 1'b1;
            if (rst_at > 0 && k == rst_at + 1) rst = 1'b0;
        end
        if (rst_at > 0) check("abort_finish", id, 64'(nf), 64'd0);
        else begin
            check("bits", id, cap & mask, bits);
            check("rises", id, 64'(nr), 64'(nb));
            check("finish_cyc", id, 64'(ff), 64'(fin));
            check("finish_cnt", id, 64'(nf), hold ? 64'd2 : 64'd1);
        end
    endtask

    initial begin
        vec_t v [9];
        logic [63:0] d;
        logic [63:0] rv;
        int i;
        int n;
        v[0] = '{0, 64'hA5C3, 64'hA5C3, 100, 1'b0, 1'b0, 0};
        v[1] = '{1, 64'h01, 64'h80, 52, 1'b0, 1'b0, 0};
        v[2] = '{0, 64'h0000, 64'h0000, 100, 1'b1, 1'b0, 0};
        v[3] = '{2, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 259, 1'b0, 1'b0, 0};
        v[4] = '{3, 64'h1, 64'h1, 10, 1'b0, 1'b0, 0};
        v[5] = '{1, 64'hB4, 64'h2D, 52, 1'b0, 1'b0, 0};
        v[6] = '{0, 64'h3C5A, 64'h3C5A3C5A, 100, 1'b0, 1'b1, 0};
        v[7] = '{0, 64'hFFFF, 64'h0, 100, 1'b0, 1'b0, 40};
        v[8] = '{0, 64'h1234, 64'h1234, 100, 1'b0, 1'b0, 0};
        for (int q = 0; q < 4; q++) begin
            t_data[q] = '0;
            t_start[q] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int q = 0; q < 4; q++) check("reset", q, 64'(obs[q]), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 9; t++)
            xfer(t, v[t].inst, v[t].d, v[t].bits, v[t].fin + LAT * HV[v[t].inst], v[t].ign, v[t].hold, v[t].rst_at);
        for (int t = 0; t < 12; t++) begin
            i = int'($urandom_range(0, 3));
            n = NV[i];
            d = {$urandom, $urandom};
            if (n < 64) d = d & ((64'd1 << n) - 64'd1);
            rv = '0;
            for (int b = 0; b < n; b++) rv[n - 1 - b] = d[b];
            xfer(100 + t, i, d, EV[i] != 0 ? d : rv, 1 + HV[i] + 2 * HV[i] * n + LAT * HV[i], 1'b0, 1'b0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
